dram_line_sequencer: RTL and testbench

- Sits directly upstream of the ML505 MIG DRAM controller wrapper and drives its mem_controller_interface-style signals: address FIFO, write buffer and read buffer.
- Converts single-cycle 256-bit cache-line requests from the cache/memory arbiter into MIG commands.
- A write becomes two 128-bit write-buffer beats followed by one address-FIFO write command.
- A read becomes one address-FIFO read command, then two read-buffer beats reassembled into a 256-bit response.
- One request is in flight at a time.

---
 rtl/dram_line_sequencer_if.sv | 69 ++++++
 rtl/dram_line_sequencer.sv | 157 +++++++++++++++
 tb/tb_dram_line_sequencer.sv | 530 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_line_sequencer_if.sv
// Cache-arbiter request/response plus MIG AF/WB/RB signal bundle.
// slave = sequencer side; master = arbiter and MIG side.
interface dram_line_sequencer_if #(
  parameter int ADDR_W = 28
);
  logic              dram_ready;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [255:0]      req_wdata;
  logic              rsp_valid;
  logic [255:0]      rsp_data;
  logic              err_timeout;
  logic              af_wren;
  logic [ADDR_W-1:0] af_addr;
  logic              af_read;
  logic              af_full;
  logic              wb_wren;
  logic [127:0]      wb_data;
  logic              wb_full;
  logic              rb_re;
  logic              rb_empty;
  logic [127:0]      rb_data;

  modport slave (
    input  dram_ready,
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    input  af_full,
    input  wb_full,
    input  rb_empty,
    input  rb_data,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output err_timeout,
    output af_wren,
    output af_addr,
    output af_read,
    output wb_wren,
    output wb_data,
    output rb_re
  );

  modport master (
    output dram_ready,
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    output af_full,
    output wb_full,
    output rb_empty,
    output rb_data,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  err_timeout,
    input  af_wren,
    input  af_addr,
    input  af_read,
    input  wb_wren,
    input  wb_data,
    input  rb_re
  );
endinterface

// File: rtl/dram_line_sequencer.sv
// Turns 256-bit line requests into MIG address-FIFO / write-buffer /
// read-buffer traffic, one request in flight, with a read watchdog.
module dram_line_sequencer #(
  parameter int ADDR_W  = 28,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input logic                  clk,
  input logic                  rstn,
  dram_line_sequencer_if.slave bus
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    WB0,
    WB1,
    WCMD,
    RCMD,
    RB0,
    RB1,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [127:0]      wb_q, wb_d;
  logic [127:0]      stage_q, stage_d;
  logic [255:0]      rsp_q, rsp_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              err_q, err_d;

  logic req_ready;
  logic rsp_valid;
  logic af_wren;
  logic af_read;
  logic wb_wren;
  logic rb_re;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wb_d      = wb_q;
    stage_d   = stage_q;
    rsp_d     = rsp_q;
    to_d      = to_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    af_wren   = 1'b0;
    af_read   = 1'b0;
    wb_wren   = 1'b0;
    rb_re     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = bus.dram_ready;
        if (bus.req_valid && bus.dram_ready) begin
          addr_d = bus.req_addr;
          if (bus.req_we) begin
            wb_d    = bus.req_wdata[127:0];
            stage_d = bus.req_wdata[255:128];
            state_d = WB0;
          end else begin
            state_d = RCMD;
          end
        end
      end
      WB0: begin
        if (!bus.wb_full) begin
          wb_wren = 1'b1;
          wb_d    = stage_q;
          state_d = WB1;
        end
      end
      WB1: begin
        if (!bus.wb_full) begin
          wb_wren = 1'b1;
          state_d = WCMD;
        end
      end
      WCMD: begin
        if (!bus.af_full) begin
          af_wren = 1'b1;
          state_d = IDLE;
        end
      end
      RCMD: begin
        if (!bus.af_full) begin
          af_wren = 1'b1;
          af_read = 1'b1;
          to_d    = '0;
          state_d = RB0;
        end
      end
      RB0: begin
        if (!bus.rb_empty) begin
          rb_re   = 1'b1;
          stage_d = bus.rb_data;
          to_d    = '0;
          state_d = RB1;
        end else if (to_q != TO_MAX) begin
          to_d = to_q + TO_ONE;
        end
      end
      RB1: begin
        // beat 0 waits in stage_q so rsp_data only changes as a whole line
        if (!bus.rb_empty) begin
          rb_re   = 1'b1;
          rsp_d   = {bus.rb_data, stage_q};
          to_d    = '0;
          state_d = RESP;
        end else if (to_q != TO_MAX) begin
          to_d = to_q + TO_ONE;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d = err_q | (to_d == TO_MAX);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wb_q    <= '0;
      stage_q <= '0;
      rsp_q   <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wb_q    <= wb_d;
      stage_q <= stage_d;
      rsp_q   <= rsp_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_data    = rsp_q;
  assign bus.err_timeout = err_q;
  assign bus.af_wren     = af_wren;
  assign bus.af_addr     = addr_q;
  assign bus.af_read     = af_read;
  assign bus.wb_wren     = wb_wren;
  assign bus.wb_data     = wb_q;
  assign bus.rb_re       = rb_re;

endmodule

// File: tb/tb_dram_line_sequencer.sv
// Scoreboard bench for dram_line_sequencer: MIG buffer model,
// negedge monitor, one task per scenario.
`timescale 1ns/1ps
module tb_dram_line_sequencer;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  dram_line_sequencer_if #(.ADDR_W(28)) bus();

  dram_line_sequencer #(
    .ADDR_W (28),
    .TIMEOUT(16),
    .TO_W   (5)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_wb     = 0;
  int n_af     = 0;
  int n_rb     = 0;
  int n_rsp    = 0;
  int pops_req = 0;
  int pops_done = 0;
  int acc_cyc, af_cyc, rsp_cyc, wb_cyc_prev, wb_cyc_last;

  logic [127:0] wb_exp[$];
  logic [28:0]  af_exp[$];
  logic [255:0] rsp_exp[$];
  logic [127:0] rb_q[$];

  bit stall_rand  = 0;
  bit tb_wb_full  = 0;
  bit tb_af_full  = 0;
  bit gap         = 0;
  int rb_gap_mode = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // MIG buffer model: inputs change 2 ns after each rising edge
  initial begin
    bus.wb_full  = 1'b0;
    bus.af_full  = 1'b0;
    bus.rb_empty = 1'b1;
    bus.rb_data  = '0;
    forever begin
      @(posedge clk);
      while (pops_done < pops_req) begin
        if (rb_q.size() > 0) rb_q.delete(0);
        pops_done++;
      end
      #2;
      case (rb_gap_mode)
        1: gap = ~gap;
        2: gap = 1'($urandom_range(0, 1));
        default: gap = 1'b0;
      endcase
      bus.rb_empty = gap || (rb_q.size() == 0);
      bus.rb_data  = (rb_q.size() > 0 && !gap) ? rb_q[0]
                                               : 128'hDEAD_BEEF;
      if (stall_rand) begin
        bus.wb_full = 1'($urandom_range(0, 1));
        bus.af_full = 1'($urandom_range(0, 1));
      end else begin
        bus.wb_full = tb_wb_full;
        bus.af_full = tb_af_full;
      end
    end
  end

  initial forever begin
    logic [127:0] e128;
    logic [28:0]  e29;
    logic [255:0] e256;
    @(negedge clk);
    if (bus.wb_wren === 1'b1) begin
      n_wb++;
      wb_cyc_prev = wb_cyc_last;
      wb_cyc_last = cyc;
      n_checks++;
      if (bus.wb_full !== 1'b0) begin
        n_fail++;
        $display("FAIL wb_while_full wb_full=%b required 0", bus.wb_full);
      end
      n_checks++;
      if (wb_exp.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected got %h required none", bus.wb_data);
      end else begin
        e128 = wb_exp.pop_front();
        if (bus.wb_data !== e128) begin
          n_fail++;
          $display("FAIL wb_data got %h required %h", bus.wb_data, e128);
        end
      end
    end
    if (bus.af_wren === 1'b1) begin
      n_af++;
      af_cyc = cyc;
      n_checks++;
      if (bus.af_full !== 1'b0) begin
        n_fail++;
        $display("FAIL af_while_full af_full=%b required 0", bus.af_full);
      end
      n_checks++;
      if (af_exp.size() == 0) begin
        n_fail++;
        $display("FAIL af_unexpected got %h/%b required none",
                 bus.af_addr, bus.af_read);
      end else begin
        e29 = af_exp.pop_front();
        if ({bus.af_addr, bus.af_read} !== e29) begin
          n_fail++;
          $display("FAIL af_cmd got %h/%b required %h/%b",
                   bus.af_addr, bus.af_read, e29[28:1], e29[0]);
        end
      end
    end
    if (bus.rb_re === 1'b1) begin
      n_rb++;
      pops_req++;
      n_checks++;
      if (bus.rb_empty !== 1'b0) begin
        n_fail++;
        $display("FAIL rb_while_empty rb_empty=%b required 0",
                 bus.rb_empty);
      end
    end
    if (bus.rsp_valid === 1'b1) begin
      n_rsp++;
      rsp_cyc = cyc;
      n_checks++;
      if (rsp_exp.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected got %h required none", bus.rsp_data);
      end else begin
        e256 = rsp_exp.pop_front();
        if (bus.rsp_data !== e256) begin
          n_fail++;
          $display("FAIL rsp_data got %h required %h", bus.rsp_data, e256);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic issue(input bit we, input logic [27:0] a,
                       input logic [255:0] d, input logic [255:0] rsp);
    int n = 0;
    bit ok = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        ok = 1;
        acc_cyc = cyc;
      end
      n++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_wait req_ready=%b required 1", bus.req_ready);
    end else if (we) begin
      wb_exp.push_back(d[127:0]);
      wb_exp.push_back(d[255:128]);
      af_exp.push_back({a, 1'b0});
    end else begin
      af_exp.push_back({a, 1'b1});
      rsp_exp.push_back(rsp);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom_range(0, 1));
    bus.req_addr  = 28'($urandom);
    bus.req_wdata = rnd256();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((wb_exp.size() + af_exp.size() + rsp_exp.size()) != 0
           && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if ((wb_exp.size() + af_exp.size() + rsp_exp.size()) != 0) begin
      n_fail++;
      $display("FAIL drain pending wb=%0d af=%0d rsp=%0d required 0",
               wb_exp.size(), af_exp.size(), rsp_exp.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.dram_ready = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.af_wren, bus.wb_wren, bus.rb_re, bus.rsp_valid,
         bus.err_timeout, bus.af_read} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl got af%b wb%b rb%b rv%b er%b rd%b required 0",
               bus.af_wren, bus.wb_wren, bus.rb_re, bus.rsp_valid,
               bus.err_timeout, bus.af_read);
    end
    n_checks++;
    if (bus.rsp_data !== 256'b0 || bus.wb_data !== 128'b0
        || bus.af_addr !== 28'b0) begin
      n_fail++;
      $display("FAIL reset_data got rsp=%h wb=%h af=%h required 0",
               bus.rsp_data, bus.wb_data, bus.af_addr);
    end
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got %b required 0", bus.req_ready);
    end
    rstn = 1'b1;
    @(posedge clk);
    #1;
    bus.dram_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready got %b required 1", bus.req_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    logic [255:0] d;
    d = {128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB,
         128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA};
    issue(1'b1, 28'h000_0123, d, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.req_ready !== (k == 3)) begin
        n_fail++;
        $display("FAIL write_busy_ready k=%0d got %b required %b",
                 k, bus.req_ready, (k == 3));
      end
    end
    wait_idle();
    n_checks++;
    if (af_cyc - acc_cyc != 3) begin
      n_fail++;
      $display("FAIL write_latency got %0d required 3", af_cyc - acc_cyc);
    end
    n_checks++;
    if (wb_cyc_last - wb_cyc_prev != 1) begin
      n_fail++;
      $display("FAIL write_beat_gap got %0d required 1",
               wb_cyc_last - wb_cyc_prev);
    end
  endtask

  task automatic test_read();
    logic [127:0] b0, b1;
    int rb0;
    b0 = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
    b1 = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
    rb0 = n_rb;
    rb_q.push_back(b0);
    rb_q.push_back(b1);
    issue(1'b0, 28'h0AB_CDEF, rnd256(), {b1, b0});
    wait_idle();
    n_checks++;
    if (rsp_cyc - acc_cyc != 4) begin
      n_fail++;
      $display("FAIL read_latency got %0d required 4", rsp_cyc - acc_cyc);
    end
    n_checks++;
    if (n_rb - rb0 != 2) begin
      n_fail++;
      $display("FAIL read_pops got %0d required 2", n_rb - rb0);
    end
  endtask

  task automatic test_backpressure();
    int wb0, af0;
    wb0 = n_wb;
    af0 = n_af;
    issue(1'b1, 28'h555_0001, rnd256(), '0);
    @(posedge clk);
    #1 tb_wb_full = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    tb_wb_full = 1'b0;
    tb_af_full = 1'b1;
    repeat (4) @(posedge clk);
    #1 tb_af_full = 1'b0;
    wait_idle();
    n_checks++;
    if (n_wb - wb0 != 2 || n_af - af0 != 1) begin
      n_fail++;
      $display("FAIL bp_counts got wb=%0d af=%0d required wb=2 af=1",
               n_wb - wb0, n_af - af0);
    end
    n_checks++;
    if (wb_cyc_last - wb_cyc_prev != 6) begin
      n_fail++;
      $display("FAIL bp_beat_gap got %0d required 6",
               wb_cyc_last - wb_cyc_prev);
    end
    n_checks++;
    if (af_cyc - acc_cyc != 11) begin
      n_fail++;
      $display("FAIL bp_cmd_latency got %0d required 11", af_cyc - acc_cyc);
    end
  endtask

  task automatic test_read_gaps();
    logic [127:0] b0, b1;
    int rb0;
    b0 = rnd256()[127:0];
    b1 = rnd256()[127:0];
    rb0 = n_rb;
    rb_gap_mode = 1;
    rb_q.push_back(b0);
    rb_q.push_back(b1);
    issue(1'b0, 28'h123_4567, rnd256(), {b1, b0});
    wait_idle();
    rb_gap_mode = 0;
    n_checks++;
    if (n_rb - rb0 != 2) begin
      n_fail++;
      $display("FAIL gap_pops got %0d required 2", n_rb - rb0);
    end
  endtask

  task automatic test_timeout();
    logic [127:0] b0, b1;
    b0 = 128'hC0C0_0000_0000_0000_0000_0000_0000_0001;
    b1 = 128'hC0C0_0000_0000_0000_0000_0000_0000_0002;
    issue(1'b0, 28'h0F0_0F00, rnd256(), {b1, b0});
    @(negedge clk);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 15) begin
        n_checks++;
        if (bus.err_timeout !== 1'b0) begin
          n_fail++;
          $display("FAIL to_early wait=%0d got %b required 0",
                   k, bus.err_timeout);
        end
      end
      if (k == 17 || k == 22) begin
        n_checks++;
        if (bus.err_timeout !== 1'b1) begin
          n_fail++;
          $display("FAIL to_set wait=%0d got %b required 1",
                   k, bus.err_timeout);
        end
      end
    end
    @(posedge clk);
    #1;
    rb_q.push_back(b0);
    rb_q.push_back(b1);
    wait_idle();
    n_checks++;
    if (bus.err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL to_sticky got %b required 1", bus.err_timeout);
    end
  endtask

  task automatic test_reset_mid();
    int wb0;
    issue(1'b1, 28'h777_7777, rnd256(), '0);
    @(posedge clk);
    #1 tb_wb_full = 1'b1;
    repeat (2) @(posedge clk);
    #1 tb_wb_full = 1'b0;
    #2;
    n_checks++;
    if (bus.wb_wren !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_wb1_active got %b required 1", bus.wb_wren);
    end
    wb0 = n_wb;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({bus.wb_wren, bus.af_wren, bus.err_timeout} !== 3'b0) begin
      n_fail++;
      $display("FAIL mid_rst_ctl got wb%b af%b er%b required 0",
               bus.wb_wren, bus.af_wren, bus.err_timeout);
    end
    n_checks++;
    if (bus.wb_data !== 128'b0 || bus.af_addr !== 28'b0
        || bus.rsp_data !== 256'b0) begin
      n_fail++;
      $display("FAIL mid_rst_data got wb=%h af=%h rsp=%h required 0",
               bus.wb_data, bus.af_addr, bus.rsp_data);
    end
    wb_exp.delete();
    af_exp.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1 || n_wb != wb0) begin
      n_fail++;
      $display("FAIL mid_rst_idle got ready=%b wb=%0d required 1/0",
               bus.req_ready, n_wb - wb0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_dram_ready();
    int wb0, af0;
    wb0 = n_wb;
    af0 = n_af;
    bus.dram_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL not_ready k=%0d got %b required 0",
                 k, bus.req_ready);
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.dram_ready = 1'b1;
    issue(1'b1, 28'h0DD_0000, rnd256(), '0);
    bus.dram_ready = 1'b0;
    wait_idle();
    bus.dram_ready = 1'b1;
    n_checks++;
    if (n_wb - wb0 != 2 || n_af - af0 != 1) begin
      n_fail++;
      $display("FAIL drop_ready got wb=%0d af=%0d required wb=2 af=1",
               n_wb - wb0, n_af - af0);
    end
  endtask

  task automatic test_back_to_back();
    int wb0, af0, rb0, nw, nr;
    logic [127:0] b0, b1;
    bit we;
    wb0 = n_wb;
    af0 = n_af;
    rb0 = n_rb;
    nw = 0;
    nr = 0;
    stall_rand  = 1;
    rb_gap_mode = 2;
    for (int i = 0; i < 16; i++) begin
      we = 1'($urandom_range(0, 1));
      if (we) begin
        nw++;
        issue(1'b1, 28'($urandom), rnd256(), '0);
      end else begin
        nr++;
        b0 = rnd256()[127:0];
        b1 = rnd256()[255:128];
        rb_q.push_back(b0);
        rb_q.push_back(b1);
        issue(1'b0, 28'($urandom), rnd256(), {b1, b0});
      end
    end
    wait_idle();
    stall_rand  = 0;
    rb_gap_mode = 0;
    n_checks++;
    if (n_wb - wb0 != 2 * nw || n_af - af0 != nw + nr
        || n_rb - rb0 != 2 * nr) begin
      n_fail++;
      $display("FAIL b2b_counts got wb=%0d af=%0d rb=%0d required %0d/%0d/%0d",
               n_wb - wb0, n_af - af0, n_rb - rb0, 2 * nw, nw + nr, 2 * nr);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_read_gaps();
    test_timeout();
    test_reset_mid();
    test_dram_ready();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
